// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the Ethernet frame receive path.
//   state_t    : FSM states of read_frame_func
//   eth_hdr_t  : latched Ethernet header (dest MAC, src MAC, EtherType)
package eth_frame_pkg;

  localparam int MAC_WIDTH     = 48;
  localparam int ETHTYPE_WIDTH = 16;
  localparam int BYTE_WIDTH    = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [MAC_WIDTH-1:0]     dest_mac;
    logic [MAC_WIDTH-1:0]     src_mac;
    logic [ETHTYPE_WIDTH-1:0] eth_type;
  } eth_hdr_t;

endpackage

// File: rtl/read_frame_func_if.sv
// Bus bundle for read_frame_func: eth_rx header channel, payload AXI-stream
// and the byte-RAM write port.
//   master : RX core / buffer side (drives header and payload, sees readies
//            and the RAM write port)
//   slave  : read_frame_func side
interface read_frame_func_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                                      m_eth_hdr_valid;
  logic                                      m_eth_hdr_ready;
  logic [eth_frame_pkg::MAC_WIDTH-1:0]       m_eth_dest_mac;
  logic [eth_frame_pkg::MAC_WIDTH-1:0]       m_eth_src_mac;
  logic [eth_frame_pkg::ETHTYPE_WIDTH-1:0]   m_eth_type;
  logic [eth_frame_pkg::BYTE_WIDTH-1:0]      m_eth_payload_axis_tdata;
  logic                                      m_eth_payload_axis_tvalid;
  logic                                      m_eth_payload_axis_tready;
  logic                                      m_eth_payload_axis_tlast;
  logic                                      m_eth_payload_axis_tuser;
  logic [ADDR_WIDTH-1:0]                     buf_waddr;
  logic [eth_frame_pkg::BYTE_WIDTH-1:0]      buf_wdata;
  logic                                      buf_wen;

  modport master (
    output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
    output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
    input  m_eth_hdr_ready, m_eth_payload_axis_tready,
    input  buf_waddr, buf_wdata, buf_wen
  );

  modport slave (
    input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
    input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
    output m_eth_hdr_ready, m_eth_payload_axis_tready,
    output buf_waddr, buf_wdata, buf_wen
  );

endinterface

// File: rtl/read_frame_func.sv
// Receives one Ethernet frame per start request: latches the header, writes
// each payload byte into an external byte RAM and reports length/error with
// a one-cycle valid pulse.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               frame request, sampled in IDLE only
//   busy, valid         FSM not idle / completion pulse
//   len, err            bytes written / bad frame or overflow
//   dest_mac, src_mac,
//   eth_type            latched header fields
//   eth                 header + payload stream + RAM write port
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, all readies low
// HDR     | hdr_ready high, waiting for header
// PAYLOAD | tready high, each beat written to RAM at counter
// DRAIN   | buffer full, discarding beats until tlast
// DONE    | valid pulse, back to IDLE
module read_frame_func
  import eth_frame_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     valid,
  output logic [LEN_WIDTH-1:0]     len,
  output logic                     err,
  output logic [MAC_WIDTH-1:0]     dest_mac,
  output logic [MAC_WIDTH-1:0]     src_mac,
  output logic [ETHTYPE_WIDTH-1:0] eth_type,
  read_frame_func_if.slave         eth
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  err_q;
  eth_hdr_t              hdr_q;

  logic hdr_ready, tready, wen;
  logic cnt_last;

  assign cnt_last = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    valid     = 1'b0;
    hdr_ready = 1'b0;
    tready    = 1'b0;
    wen       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        hdr_ready = 1'b1;
        if (eth.m_eth_hdr_valid) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        tready = 1'b1;
        wen    = eth.m_eth_payload_axis_tvalid;
        if (eth.m_eth_payload_axis_tvalid) begin
          // tlast takes priority: a full-size frame ending exactly at the
          // last address is legal and must not enter DRAIN
          if (eth.m_eth_payload_axis_tlast) state_d = DONE;
          else if (cnt_last)                state_d = DRAIN;
        end
      end
      DRAIN: begin
        tready = 1'b1;
        if (eth.m_eth_payload_axis_tvalid && eth.m_eth_payload_axis_tlast)
          state_d = DONE;
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
      hdr_q <= '0;
    end else begin
      if (state_q == HDR && eth.m_eth_hdr_valid) begin
        hdr_q <= '{dest_mac: eth.m_eth_dest_mac,
                   src_mac:  eth.m_eth_src_mac,
                   eth_type: eth.m_eth_type};
        cnt_q <= '0;
        len_q <= '0;
        err_q <= 1'b0;
      end
      if (state_q == PAYLOAD && eth.m_eth_payload_axis_tvalid) begin
        cnt_q <= cnt_q + 1'b1;
        // on overflow counter+1 equals MAX_LEN, so one expression covers both
        if (eth.m_eth_payload_axis_tlast || cnt_last) begin
          len_q <= LEN_WIDTH'(cnt_q) + LEN_WIDTH'(1);
          err_q <= eth.m_eth_payload_axis_tlast ? eth.m_eth_payload_axis_tuser : 1'b1;
        end
      end
    end
  end

  assign len      = len_q;
  assign err      = err_q;
  assign dest_mac = hdr_q.dest_mac;
  assign src_mac  = hdr_q.src_mac;
  assign eth_type = hdr_q.eth_type;

  assign eth.m_eth_hdr_ready           = hdr_ready;
  assign eth.m_eth_payload_axis_tready = tready;
  assign eth.buf_wen                   = wen;
  assign eth.buf_waddr                 = cnt_q;
  assign eth.buf_wdata                 = eth.m_eth_payload_axis_tdata;

endmodule

// File: tb/tb_read_frame_func.sv
// Bench for read_frame_func: an 8-bit-address instance for the general
// cases and a 4-bit-address instance for full-buffer and overflow frames.
// Both share the stimulus signals; only the selected one is started.
module tb_read_frame_func;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start8 = 1'b0, start4 = 1'b0;
  logic hdr_valid = 1'b0;
  logic [47:0] hdr_dest = '0, hdr_src = '0;
  logic [15:0] hdr_type = '0;
  logic [7:0]  tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic ram_clr = 1'b0;

  logic busy8, valid8, err8, busy4, valid4, err4;
  logic [8:0]  len8;
  logic [4:0]  len4;
  logic [47:0] dm8, sm8, dm4, sm4;
  logic [15:0] et8, et4;

  read_frame_func_if #(.ADDR_WIDTH(8)) bus8 ();
  read_frame_func_if #(.ADDR_WIDTH(4)) bus4 ();

  assign bus8.m_eth_hdr_valid = hdr_valid;
  assign bus8.m_eth_dest_mac = hdr_dest;
  assign bus8.m_eth_src_mac = hdr_src;
  assign bus8.m_eth_type = hdr_type;
  assign bus8.m_eth_payload_axis_tdata = tdata;
  assign bus8.m_eth_payload_axis_tvalid = tvalid;
  assign bus8.m_eth_payload_axis_tlast = tlast;
  assign bus8.m_eth_payload_axis_tuser = tuser;
  assign bus4.m_eth_hdr_valid = hdr_valid;
  assign bus4.m_eth_dest_mac = hdr_dest;
  assign bus4.m_eth_src_mac = hdr_src;
  assign bus4.m_eth_type = hdr_type;
  assign bus4.m_eth_payload_axis_tdata = tdata;
  assign bus4.m_eth_payload_axis_tvalid = tvalid;
  assign bus4.m_eth_payload_axis_tlast = tlast;
  assign bus4.m_eth_payload_axis_tuser = tuser;

  read_frame_func #(.ADDR_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .valid(valid8),
    .len(len8), .err(err8), .dest_mac(dm8), .src_mac(sm8), .eth_type(et8),
    .eth(bus8)
  );

  read_frame_func #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .valid(valid4),
    .len(len4), .err(err4), .dest_mac(dm4), .src_mac(sm4), .eth_type(et4),
    .eth(bus4)
  );

  // behavioural byte RAMs
  logic [7:0] ram8 [256];
  logic [7:0] ram4 [16];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram8[i] <= 8'h00;
      for (int i = 0; i < 16; i++)  ram4[i] <= 8'h00;
    end else begin
      if (bus8.buf_wen) ram8[bus8.buf_waddr] <= bus8.buf_wdata;
      if (bus4.buf_wen) ram4[bus4.buf_waddr] <= bus4.buf_wdata;
    end
  end

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit          sel;
    int          len;
    bit          err;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    int          nwr;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] pl [32];

  // edge tracker: cycle count, writes since header accept, tlast beat cycle
  int cyc = 0, wr8 = 0, wr4 = 0, hacc8 = 0, last_tl = -10;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (bus8.m_eth_hdr_valid && bus8.m_eth_hdr_ready) begin wr8 = 0; hacc8++; end
    else if (bus8.buf_wen) wr8++;
    if (bus4.m_eth_hdr_valid && bus4.m_eth_hdr_ready) wr4 = 0;
    else if (bus4.buf_wen) wr4++;
    if (tvalid && tlast && (bus8.m_eth_payload_axis_tready || bus4.m_eth_payload_axis_tready))
      last_tl = cyc;
  end

  // scoreboard monitor
  bit pv8 = 0, pv4 = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus8.buf_wen) chk("wen8_without_tvalid", tvalid, 1);
      if (bus4.buf_wen) chk("wen4_without_tvalid", tvalid, 1);
      if (pv8) chk("valid8_pulse_then_idle", {valid8, busy8}, 2'b00);
      if (pv4) chk("valid4_pulse_then_idle", {valid4, busy4}, 2'b00);
      if (valid8 || valid4) begin
        if (sbq.size() == 0) chk("unexpected_valid", sbq.size(), 1);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("valid_source", valid4, e.sel);
          chk("len",  e.sel ? 64'(len4) : 64'(len8), e.len);
          chk("err",  e.sel ? err4 : err8, e.err);
          chk("dest_mac", e.sel ? dm4 : dm8, e.dest);
          chk("src_mac",  e.sel ? sm4 : sm8, e.src);
          chk("eth_type", e.sel ? et4 : et8, e.etype);
          chk("write_count", e.sel ? wr4 : wr8, e.nwr);
          chk("valid_latency", cyc, last_tl);
        end
      end
    end
    pv8 = valid8;
    pv4 = valid4;
  end

  task automatic wait_hdr(input bit sel);
    int k = 0;
    do begin @(posedge clk); k++; end
    while (!(sel ? bus4.m_eth_hdr_ready : bus8.m_eth_hdr_ready) && k < 100);
    chk("hdr_handshake", sel ? bus4.m_eth_hdr_ready : bus8.m_eth_hdr_ready, 1);
    #1;
  endtask

  task automatic wait_beat(input bit sel);
    int k = 0;
    do begin @(posedge clk); k++; end
    while (!(sel ? bus4.m_eth_payload_axis_tready : bus8.m_eth_payload_axis_tready) && k < 100);
    chk("beat_handshake", sel ? bus4.m_eth_payload_axis_tready : bus8.m_eth_payload_axis_tready, 1);
    #1;
  endtask

  task automatic wait_idle(input bit sel);
    int k = 0;
    do begin @(negedge clk); k++; end
    while ((sel ? busy4 : busy8) && k < 200);
    chk("return_to_idle", sel ? busy4 : busy8, 0);
  endtask

  task automatic send_payload(input bit sel, input int off, input int n,
                              input bit tu, input int gap, input bit with_last);
    for (int i = 0; i < n; i++) begin
      tvalid = 1; tdata = pl[off+i];
      tlast = with_last && (i == n-1);
      tuser = tu && (i == n-1);
      wait_beat(sel);
      tvalid = 0; tlast = 0; tuser = 0;
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
    end
  endtask

  task automatic set_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    hdr_dest = d; hdr_src = s; hdr_type = t;
  endtask

  task automatic clear_ram();
    @(posedge clk); #1 ram_clr = 1;
    @(posedge clk); #1 ram_clr = 0;
  endtask

  task automatic start_hdr(input bit sel);
    if (sel) start4 = 1; else start8 = 1;
    @(posedge clk); #1;
    start4 = 0; start8 = 0;
    hdr_valid = 1;
    wait_hdr(sel);
    hdr_valid = 0;
  endtask

  task automatic run_frame(input bit sel, input int n, input bit tu, input int gap,
                           input int exp_len, input bit exp_err, input int exp_nwr);
    sbq.push_back('{sel, exp_len, exp_err, hdr_dest, hdr_src, hdr_type, exp_nwr});
    clear_ram();
    start_hdr(sel);
    send_payload(sel, 0, n, tu, gap, 1);
    wait_idle(sel);
    for (int i = 0; i < exp_nwr; i++)
      chk($sformatf("ram[%0d]", i), sel ? ram4[i] : ram8[i], pl[i]);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_len", len8, 0);
    chk("rst_err", err8, 0);
    chk("rst_dest", dm8, 0);
    chk("rst_src", sm8, 0);
    chk("rst_type", et8, 0);
    chk("rst_readies", {bus8.m_eth_hdr_ready, bus8.m_eth_payload_axis_tready}, 0);
    chk("rst_wen", bus8.buf_wen, 0);
    chk("rst_waddr", bus8.buf_waddr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    chk("rst_busy4", busy4, 0);
    #2 rst_n = 1;

    // basic 4-byte frame
    set_hdr(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800);
    for (int i = 0; i < 4; i++) pl[i] = 8'(i + 1);
    run_frame(0, 4, 0, 0, 4, 0, 4);

    // same frame with tvalid 1 on / 2 off
    run_frame(0, 4, 0, 2, 4, 0, 4);

    // reset mid-payload after 3 bytes, then a 2-byte frame
    set_hdr(48'h665544332211, 48'h0F0E0D0C0B0A, 16'h88B5);
    start_hdr(0);
    send_payload(0, 0, 3, 0, 0, 0);
    rst_n = 0;
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    chk("rst_mid_busy", busy8, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy8, 0);
    set_hdr(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h86DD);
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    run_frame(0, 2, 0, 0, 2, 0, 2);

    // 1-byte bad frame
    set_hdr(48'h010203040506, 48'hA1A2A3A4A5A6, 16'h0806);
    pl[0] = 8'hA5;
    run_frame(0, 1, 1, 0, 1, 1, 1);

    // 4-bit buffer: exactly full, then overflow
    for (int i = 0; i < 20; i++) pl[i] = 8'h30 + 8'(i);
    set_hdr(48'h0000000000AA, 48'h0000000000BB, 16'h1234);
    run_frame(1, 16, 0, 0, 16, 0, 16);
    set_hdr(48'h0000000000CC, 48'h0000000000DD, 16'h5678);
    run_frame(1, 20, 0, 0, 16, 1, 16);

    // back-to-back frames with start and hdr_valid held high
    for (int i = 0; i < 5; i++) pl[i] = 8'h10 + 8'(i);
    set_hdr(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0801);
    sbq.push_back('{0, 3, 0, hdr_dest, hdr_src, hdr_type, 3});
    sbq.push_back('{0, 2, 0, hdr_dest, hdr_src, hdr_type, 2});
    clear_ram();
    h0 = hacc8;
    start8 = 1; hdr_valid = 1;
    send_payload(0, 0, 3, 0, 0, 1);
    send_payload(0, 3, 2, 0, 0, 1);
    start8 = 0; hdr_valid = 0;
    wait_idle(0);
    chk("b2b_hdr_accepts", hacc8 - h0, 2);
    chk("b2b_ram0", ram8[0], 8'h13);
    chk("b2b_ram1", ram8[1], 8'h14);
    chk("b2b_ram2", ram8[2], 8'h12);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/read_frame_func.md
Name: read_frame_func

Overview:
- Receive-side counterpart of the byte-write function.
- Accepts one Ethernet frame from the eth_rx AXI-stream header/payload interface and writes each payload byte into an external byte RAM through a write port.
- Reports the frame length, header fields and error status with a one-cycle valid pulse.
- Sits between the Ethernet RX MAC/eth_axis_rx core and HLS-generated consumer kernels that read the buffer.

Parameters:
ADDR_WIDTH, 8, buffer address width; buffer capacity MAX_LEN = 2**ADDR_WIDTH bytes
LEN_WIDTH, ADDR_WIDTH+1, width of the length result (holds 0..MAX_LEN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to receive one frame; sampled only in IDLE
busy  out  1  high whenever state != IDLE
valid  out  1  one-cycle completion pulse
len  out  LEN_WIDTH  number of bytes written to buffer for the last frame
err  out  1  frame ended with tuser=1, or overflowed the buffer
dest_mac  out  48  latched header destination MAC
src_mac  out  48  latched header source MAC
eth_type  out  16  latched header EtherType
m_eth_hdr_valid  in  1  header valid from RX core
m_eth_hdr_ready  out  1  header ready
m_eth_dest_mac  in  48  header destination MAC
m_eth_src_mac  in  48  header source MAC
m_eth_type  in  16  header EtherType
m_eth_payload_axis_tdata  in  8  payload byte
m_eth_payload_axis_tvalid  in  1  payload valid
m_eth_payload_axis_tready  out  1  payload ready
m_eth_payload_axis_tlast  in  1  last payload byte
m_eth_payload_axis_tuser  in  1  bad-frame flag, qualified with tlast
buf_waddr  out  ADDR_WIDTH  RAM write address
buf_wdata  out  8  RAM write data
buf_wen  out  1  RAM write enable (one byte per cycle)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values while rst_n=0:
  - State is IDLE; the byte counter is 0.
  - busy, valid, err, hdr_ready, tready and buf_wen are 0; len, dest_mac, src_mac, eth_type and buf_waddr are 0.
- Reset mid-frame aborts immediately: no valid pulse, no further writes. Stream bytes left in flight are the upstream core's concern.
- Beat: tvalid && tready. Header accept: hdr_valid && hdr_ready.
- States:
  - IDLE: all readies 0. start=1 -> HDR next cycle; start=0 -> stay.
  - HDR:
    - hdr_ready=1 (decoded from state, combinational).
    - On header accept: latch dest_mac/src_mac/eth_type, clear counter, clear err, set len=0 -> PAYLOAD.
  - PAYLOAD:
    - tready=1.
    - On a beat, same cycle and combinational: buf_wen=1, buf_waddr=counter, buf_wdata=tdata. Counter increments at the clock edge.
    - Beat with tlast=1: len<=counter+1, err<=tuser -> DONE.
    - Beat with tlast=0 while counter==MAX_LEN-1: the byte is written, len<=MAX_LEN, err<=1 -> DRAIN (overflow).
    - tvalid=0: hold, no write.
  - DRAIN:
    - tready=1, buf_wen=0; discard beats.
    - Beat with tlast=1 -> DONE; err remains 1 and len remains MAX_LEN.
  - DONE: valid=1 for exactly one cycle -> IDLE.
- Result outputs:
  - len, err and the header fields hold their values until the next header accept.
- Start handling:
  - start is ignored outside IDLE, including in DONE.
  - A new start is accepted on the IDLE cycle after DONE at the earliest.
- Latency and throughput:
  - One byte per cycle sustained in PAYLOAD.
  - valid rises 1 cycle after the tlast beat.
  - The minimum frame is a 1-byte payload. Total for that frame: start, HDR ≥1 cycle, PAYLOAD 1 cycle, DONE 1 cycle.
- Width rules:
  - The counter is ADDR_WIDTH bits; buf_waddr is the counter directly.
  - len = zero-extended counter + 1 in LEN_WIDTH bits; no wrap is possible because overflow diverts to DRAIN.
- Simultaneous events:
  - A tlast beat at counter==MAX_LEN-1 is a legal full frame: len=MAX_LEN, err=tuser, go to DONE, not DRAIN.
  - Payload beats presented during HDR are not accepted (tready=0).
  - A header presented during PAYLOAD/DRAIN is not accepted.

Decomposition:
- Shared package eth_frame_pkg:
  - State enum (IDLE, HDR, PAYLOAD, DRAIN, DONE).
  - Constants MAC_WIDTH=48, ETHTYPE_WIDTH=16, BYTE_WIDTH=8.
  - Header struct {dest_mac, src_mac, eth_type}.
- The module is a single FSM plus counter; no sub-module is warranted. The RAM is external and the bench supplies a behavioural byte RAM.

Test Plan:
- Reset during PAYLOAD after 3 bytes (rst_n low 2 cycles) -> all outputs 0, state IDLE, no valid pulse; then start plus a 2-byte frame completes with len=2.
- Start plus header {dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800}, payload 0x01..0x04 with tlast on 0x04, tuser=0 -> RAM[0..3]=01,02,03,04; valid one cycle after the tlast beat; len=4, err=0, header fields match.
- Same frame with tvalid gapped (1 on, 2 off) -> identical RAM contents and len=4; buf_wen never high when tvalid=0.
- 1-byte frame 0xA5 with tlast=1, tuser=1 -> RAM[0]=A5, len=1, err=1.
- ADDR_WIDTH=4: 16-byte frame, tlast on the 16th byte -> len=16, err=0, state DONE with no DRAIN. Then a 20-byte frame -> RAM[0..15] written, bytes 17-20 discarded without writes, len=16, err=1, valid once.
- start held high throughout two back-to-back frames -> second header not accepted until after DONE; busy low for ≥1 cycle between frames.
